// File: rtl/pic_ram_arbiter.sv
// Picture RAM arbiter: shares one single-port RGB444 RAM between the VGA reader
// (absolute priority) and the image loader (leftover cycles only).
// RAM commands are registered; read data reaches the display 2+RAM_LAT cycles
// after the request.
// Optional build macro PIC_RAM_VBLANK_ONLY_EN: loader writes only during vblank.
module pic_ram_arbiter #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned RAM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic              ld_starve,
  input  logic              vblank,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    StIdle,
    StDisp,
    StWrite
  } state_e;

  state_e            state_q;
  logic              ld_eligible;
  logic              grant_wr;
  logic [WAIT_W-1:0] wait_q;
  // Bit i set: a display read was issued i+1 cycles ago; the top bit marks
  // the cycle in which ram_dout carries that read's data.
  logic [RAM_LAT:0]  rd_pipe_q;

`ifdef PIC_RAM_VBLANK_ONLY_EN
  // Writes outside vblank would tear the displayed picture.
  always_comb ld_eligible = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  always_comb ld_eligible = 1'b1;
`endif

  // Loader gets a cycle only when the display is idle; during its own ack
  // cycle ld_req is still the request just served, so it is ignored.
  always_comb begin
    grant_wr = 1'b0;
    if (!disp_req && ld_req && ld_eligible && (state_q != StWrite)) begin
      grant_wr = 1'b1;
    end
  end

  // Arbitration FSM with registered RAM command and ack outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      ld_ack   <= 1'b0;
    end else begin
      ram_we <= grant_wr;
      ld_ack <= grant_wr;
      if (disp_req) begin
        state_q  <= StDisp;
        ram_addr <= disp_addr;
      end else if (grant_wr) begin
        state_q  <= StWrite;
        ram_addr <= ld_addr;
        ram_din  <= ld_wdata;
      end else begin
        state_q <= StIdle;
      end
    end
  end

  // Loader wait counter: counts unserved request cycles, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else if (grant_wr) begin
      wait_q <= '0;
    end else if (ld_req && (wait_q != WAIT_MAX)) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  assign ld_starve = (wait_q == WAIT_MAX);

  // Read-return pipeline; disp_data holds its value between valid beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pipe_q  <= '0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      if (RAM_LAT == 0) begin
        rd_pipe_q <= {RAM_LAT+1{disp_req}};
      end else begin
        rd_pipe_q <= {rd_pipe_q[RAM_LAT-1:0], disp_req};
      end
      disp_valid <= rd_pipe_q[RAM_LAT];
      if (rd_pipe_q[RAM_LAT]) begin
        disp_data <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_pic_ram_arbiter.sv
// Bench for pic_ram_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic checked against a transaction-level model.
module tb_pic_ram_arbiter;

  localparam int RAM_LAT  = 1;
  localparam int MAXW     = 8;
  localparam int MEM_SIZE = 131072;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_req = 1'b0;
  logic [16:0] disp_addr = '0;
  logic [11:0] disp_data;
  logic        disp_valid;
  logic        ld_req = 1'b0;
  logic [16:0] ld_addr = '0;
  logic [11:0] ld_wdata = '0;
  logic        ld_ack;
  logic        ld_starve;
  logic        vblank = 1'b1;
  logic [16:0] ram_addr;
  logic [11:0] ram_din;
  logic        ram_we;
  logic [11:0] ram_dout = '0;

  int checks = 0;
  int errors = 0;

  pic_ram_arbiter #(
    .ADDR_W  (17),
    .DATA_W  (12),
    .RAM_LAT (RAM_LAT),
    .MAX_WAIT(MAXW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .ld_starve (ld_starve),
    .vblank    (vblank),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Picture RAM driven by the DUT (synchronous read, one cycle latency).
  logic [11:0] mem [MEM_SIZE];
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we === 1'b1) mem[ram_addr] <= ram_din;
  end

  // Reference model state: expected picture contents and expected outputs.
  typedef struct {
    int          due;
    logic [11:0] data;
  } rd_t;

  logic [11:0] ref_mem [MEM_SIZE];
  rd_t         rdq[$];
  int          edge_n = 0;
  int          m_wait = 0;
  logic        m_ack = 0, m_we = 0, m_valid = 0;
  logic [16:0] m_addr = '0;
  logic [11:0] m_din = '0, m_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, compare after it.
  task automatic step(input logic rst, input logic dr, input logic [16:0] da, input logic lr,
                      input logic [16:0] la, input logic [11:0] lw, input logic vb);
    logic served, elig, gw;
    @(negedge clk);
    rst_n = rst; disp_req = dr; disp_addr = da;
    ld_req = lr; ld_addr = la; ld_wdata = lw; vblank = vb;
    @(posedge clk);
    edge_n++;
    if (m_we) ref_mem[m_addr] = m_din;
    if (!rst) begin
      m_ack = 0; m_we = 0; m_addr = '0; m_din = '0;
      m_valid = 0; m_data = '0; m_wait = 0;
      rdq.delete();
    end else begin
      served = m_ack;
`ifdef PIC_RAM_VBLANK_ONLY_EN
      elig = vb;
`else
      elig = 1'b1;
`endif
      gw = lr && !dr && !served && elig;
      if (dr) begin
        rdq.push_back('{due: edge_n + 1 + RAM_LAT, data: ref_mem[da]});
        m_we = 0; m_addr = da;
      end else if (gw) begin
        m_we = 1; m_addr = la; m_din = lw;
      end else begin
        m_we = 0;
      end
      m_ack = gw;
      if (gw) m_wait = 0;
      else if (lr) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
      if (rdq.size() > 0 && rdq[0].due == edge_n) begin
        m_valid = 1; m_data = rdq[0].data;
        void'(rdq.pop_front());
      end else begin
        m_valid = 0;
      end
    end
    #1;
    check("ld_ack", 32'(ld_ack), 32'(m_ack));
    check("ram_we", 32'(ram_we), 32'(m_we));
    check("ram_addr", 32'(ram_addr), 32'(m_addr));
    check("ram_din", 32'(ram_din), 32'(m_din));
    check("disp_valid", 32'(disp_valid), 32'(m_valid));
    check("disp_data", 32'(disp_data), 32'(m_data));
    check("ld_starve", 32'(ld_starve), 32'(m_wait == MAXW));
  endtask

  typedef struct {
    logic        dr;
    logic [16:0] da;
    logic        lr;
    logic [16:0] la;
    logic [11:0] lw;
    logic        e_ack;
    logic        e_we;
    logic        e_val;
    logic [16:0] e_addr;
    logic [11:0] e_data;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int          ack_cnt;
    logic        lr;
    logic [16:0] la;
    logic [11:0] lw;

    for (int i = 0; i < MEM_SIZE; i++) begin
      mem[i] = 12'(32'h100 + i);
      ref_mem[i] = 12'(32'h100 + i);
    end

    // Reads of 0..3 then two back-to-back loader requests for the same word.
    tbl[0] = '{1, 17'd0, 0, 17'h00A, 12'hABC, 0, 0, 0, 17'd0, 12'h000};
    tbl[1] = '{1, 17'd1, 0, 17'h00A, 12'hABC, 0, 0, 0, 17'd1, 12'h000};
    tbl[2] = '{1, 17'd2, 0, 17'h00A, 12'hABC, 0, 0, 1, 17'd2, 12'h100};
    tbl[3] = '{1, 17'd3, 0, 17'h00A, 12'hABC, 0, 0, 1, 17'd3, 12'h101};
    tbl[4] = '{0, 17'd0, 1, 17'h00A, 12'hABC, 1, 1, 1, 17'h00A, 12'h102};
    tbl[5] = '{0, 17'd0, 1, 17'h00A, 12'hABC, 0, 0, 1, 17'h00A, 12'h103};
    tbl[6] = '{0, 17'd0, 1, 17'h00A, 12'hABC, 1, 1, 0, 17'h00A, 12'h103};
    tbl[7] = '{0, 17'd0, 0, 17'h00A, 12'hABC, 0, 0, 0, 17'h00A, 12'h103};

    // Reset values.
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0, '0, 1);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ld_ack", 32'(ld_ack), 32'd0);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      step(1, tbl[i].dr, tbl[i].da, tbl[i].lr, tbl[i].la, tbl[i].lw, 1);
      check($sformatf("tbl%0d_ack", i), 32'(ld_ack), 32'(tbl[i].e_ack));
      check($sformatf("tbl%0d_we", i), 32'(ram_we), 32'(tbl[i].e_we));
      check($sformatf("tbl%0d_valid", i), 32'(disp_valid), 32'(tbl[i].e_val));
      check($sformatf("tbl%0d_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
      check($sformatf("tbl%0d_data", i), 32'(disp_data), 32'(tbl[i].e_data));
    end
    check("tbl_din", 32'(ram_din), 32'h0ABC);

    // Loader blocked by 10 display cycles, granted on the first free one.
    ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 17'(40 + i), 1, 17'h030, 12'h111, 1);
      ack_cnt += int'(ld_ack);
    end
    check("t3_no_ack", 32'(ack_cnt), 32'd0);
    step(1, 0, '0, 1, 17'h030, 12'h111, 1);
    check("t3_ack", 32'(ld_ack), 32'd1);
    step(1, 0, '0, 0, 17'h030, 12'h111, 1);

    // Starvation flag: rises after MAXW waiting cycles, clears after grant.
    step(0, 0, '0, 0, '0, '0, 1);
    for (int k = 1; k <= 20; k++) begin
      step(1, 1, 17'(k), 1, 17'h031, 12'h222, 1);
      check($sformatf("t4_starve_%0d", k), 32'(ld_starve), 32'(k >= MAXW));
    end
    step(1, 0, '0, 1, 17'h031, 12'h222, 1);
    check("t4_grant", 32'(ld_ack), 32'd1);
    check("t4_starve_clr", 32'(ld_starve), 32'd0);
    step(1, 0, '0, 0, '0, '0, 1);

    // Read-after-write to the same address.
    step(1, 0, '0, 1, 17'h020, 12'h5A5, 1);
    step(1, 1, 17'h020, 1, 17'h020, 12'h5A5, 1);
    step(1, 0, '0, 0, '0, '0, 1);
    step(1, 0, '0, 0, '0, '0, 1);
    check("t5_valid", 32'(disp_valid), 32'd1);
    check("t5_data", 32'(disp_data), 32'h5A5);

    // Reset on the decision cycle of a write drops it.
    step(0, 0, '0, 1, 17'h021, 12'h777, 1);
    check("t6_we", 32'(ram_we), 32'd0);
    check("t6_ack", 32'(ld_ack), 32'd0);
    check("t6_addr", 32'(ram_addr), 32'd0);
    check("t6_starve", 32'(ld_starve), 32'd0);
    step(1, 0, '0, 0, '0, '0, 1);

`ifdef PIC_RAM_VBLANK_ONLY_EN
    // Loader waits outside vblank.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, '0, 1, 17'h022, 12'h333, 0);
      check("vb_no_ack", 32'(ld_ack), 32'd0);
    end
    step(1, 0, '0, 1, 17'h022, 12'h333, 1);
    check("vb_ack", 32'(ld_ack), 32'd1);
    step(1, 0, '0, 0, '0, '0, 1);
`endif

    // Randomized traffic; the loader holds address/data until it sees an ack.
    lr = 0; la = '0; lw = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!lr && ($urandom_range(0, 2) == 0)) begin
        lr = 1;
        la = 17'($urandom_range(0, 63));
        lw = 12'($urandom);
      end
      step(($urandom_range(0, 249) != 0), ($urandom_range(0, 99) < 60),
           17'($urandom_range(0, 63)), lr, la, lw, 1'($urandom));
      if (ld_ack) lr = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_ram_arbiter.md
Name: pic_ram_arbiter

Overview:
- Shares the single-port picture RAM (12-bit RGB444, 17-bit address) between two requesters:
  - the VGA picture reader, which has absolute priority;
  - an image loader (UART/SD write path), which gets only the cycles the reader leaves free.
- Sits between the display pipeline and the picture RAM. Issues registered RAM commands, returns read data to the display with fixed latency, and acks loader writes.

Parameters:
- ADDR_W, 17, RAM address width.
- DATA_W, 12, pixel width (RGB444).
- RAM_LAT, 1, RAM read latency in cycles (1 or 2).
- MAX_WAIT, 1023, loader wait cycles before ld_starve is raised.

Ports:
- clk  in  1  system/pixel clock.
- rst_n  in  1  synchronous active-low reset.
- disp_req  in  1  display needs a read this cycle.
- disp_addr  in  ADDR_W  display read address.
- disp_data  out  DATA_W  read data returned to the display.
- disp_valid  out  1  disp_data is valid this cycle.
- ld_req  in  1  loader has a pending write.
- ld_addr  in  ADDR_W  write address; held stable until ack.
- ld_wdata  in  DATA_W  write data; held stable until ack.
- ld_ack  out  1  one-cycle pulse: the write was issued to RAM this cycle.
- ld_starve  out  1  loader has waited at least MAX_WAIT cycles.
- vblank  in  1  vertical blanking indicator (see Optional Feature).
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_din  out  DATA_W  RAM write data (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_dout  in  DATA_W  RAM read data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - ram_addr = 0, ram_din = 0, ram_we = 0.
  - disp_data = 0, disp_valid = 0.
  - ld_ack = 0, ld_starve = 0.
  - wait counter = 0, state = IDLE.
- Arbitration decision is made at cycle t from the inputs; RAM outputs are driven at t+1.
- State machine:
  - IDLE: no access in flight.
    - disp_req=1 -> DISP.
    - else ld_req=1 (and the loader is eligible) -> WRITE.
    - else stay IDLE.
  - DISP: at t+1, ram_addr=disp_addr(t) and ram_we=0. The next decision follows the IDLE rules.
  - WRITE: at t+1, ram_addr=ld_addr, ram_din=ld_wdata, ram_we=1, ld_ack=1.
    - ld_req is ignored during the ack cycle, because the loader has not yet seen the ack.
    - From WRITE: disp_req=1 -> DISP, else -> IDLE.
    - Peak loader rate is therefore one write per 2 cycles.
- Simultaneous disp_req and ld_req: display always wins. The loader waits with no cycle lost to the display.
- Display path: disp_req at t gives disp_valid=1 and disp_data=RAM contents at t+2+RAM_LAT.
  - disp_data is registered.
  - disp_valid is a shift of disp_req with no gaps or reordering.
  - disp_data holds its last value when disp_valid=0.
- Read-after-write, same address: a write acked at t+1 followed by a display read decided at t+1 returns the new data.
- Wait counter:
  - Increments each cycle with ld_req=1 and no grant.
  - Saturates at MAX_WAIT.
  - Clears on grant.
  - ld_starve = (counter == MAX_WAIT).
  - ld_starve never overrides display priority; it is advisory only.
- Reset mid-operation: a pending or decided write is dropped. No ld_ack is issued and ram_we=0 on the next cycle.
- Loader contract: ld_addr and ld_wdata are sampled only on the decision cycle. Changing them before ld_ack is a protocol violation, and the result is undefined.

Optional Feature:
- Macro: PIC_RAM_VBLANK_ONLY_EN.
- Defined: the loader is eligible only when vblank=1 on the decision cycle. Otherwise it waits and the wait counter runs. This prevents tearing of the displayed picture.
- Undefined: vblank is ignored, and the loader uses any cycle without disp_req, including h-blank inside the visible frame.

Test Plan:
1. Reset, then disp_req=1 for 4 cycles at addresses 0..3, with RAM preloaded mem[i]=12'h100+i.
   -> disp_valid high for 4 cycles starting at t+3 (RAM_LAT=1), disp_data 0x100..0x103. ld_ack never asserted.
2. ld_req=1, ld_addr=17'h00A, ld_wdata=12'hABC, disp_req=0.
   -> ram_we=1 with ram_addr=0x00A and ram_din=0xABC one cycle later, ld_ack single pulse on that same cycle.
   -> ld_req held continuously: next ack no sooner than 2 cycles later.
3. ld_req=1 with disp_req=1 for 10 cycles, then disp_req=0.
   -> no ld_ack during the 10 cycles; ack on cycle 12. Display reads uninterrupted.
4. MAX_WAIT=8, disp_req held high for 20 cycles with ld_req=1.
   -> ld_starve rises after 8 waiting cycles and stays high; clears the cycle after grant.
5. Write 0x5A5 to addr 0x20, immediately followed by disp_req at addr 0x20 -> disp_data=0x5A5.
6. Assert rst_n=0 on the decision cycle of a write -> ram_we=0 and ld_ack=0 next cycle, all outputs at reset values.
   - PIC_RAM_VBLANK_ONLY_EN build: ld_req with vblank=0 -> no ack; vblank=1 -> ack within 2 cycles.
